hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: D-stage stall detection, D/E/M forwarding
// selects and the mult/div busy tracker. Everything except md_busy is
// combinational from the current stage tags.

// Per-source D-stage hazard check: stall decision and forwarding select
// for one D-stage register operand against the E/M/W producers.
module hazard_dsrc (
  input  logic [4:0] ra,
  input  logic [1:0] tuse,
  input  logic [4:0] waE,
  input  logic       wvE,
  input  logic [1:0] tnewE,
  input  logic [4:0] waM,
  input  logic       wvM,
  input  logic [1:0] tnewM,
  input  logic [4:0] waW,
  input  logic       wvW,
  output logic       dstall,
  output logic [1:0] fwd
);
  logic hitE, hitM, hitW;

  assign hitE = wvE && (waE == ra);
  assign hitM = wvM && (waM == ra);
  assign hitW = wvW && (waW == ra);

  // Nearest matching producer decides; tuse 3 means the operand is not read.
  always_comb begin
    dstall = 1'b0;
    if (tuse != 2'd3) begin
      if (hitE)      dstall = (tnewE > tuse);
      else if (hitM) dstall = (tnewM > tuse);
    end
  end

  // E only has a ready value for links (Tnew 0); M only when Tnew is 0.
  always_comb begin
    fwd = 2'd0;
    if (hitE && tnewE == 2'd0)      fwd = 2'd1;
    else if (hitM && tnewM == 2'd0) fwd = 2'd2;
    else if (hitW)                  fwd = 2'd3;
  end
endmodule

module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ra1D,
  input  logic [4:0] ra2D,
  input  logic [1:0] tuse1D,
  input  logic [1:0] tuse2D,
  input  logic [4:0] ra1E,
  input  logic [4:0] ra2E,
  input  logic [4:0] waE,
  input  logic [2:0] resE,
  input  logic [4:0] ra2M,
  input  logic [4:0] waM,
  input  logic [2:0] resM,
  input  logic [4:0] waW,
  input  logic [2:0] resW,
  input  logic       md_startE,
  input  logic       md_opE,
  input  logic       md_useD,
  input  logic       exc_flush,
  output logic       stall,
  output logic       DEMWclr,
  output logic [1:0] fwd1D,
  output logic [1:0] fwd2D,
  output logic [1:0] fwd1E,
  output logic [1:0] fwd2E,
  output logic       fwd2M,
  output logic       md_busy
);
  localparam int          NUM_SRC = 2;
  localparam logic [2:0]  RES_ALU = 3'd1;
  localparam logic [2:0]  RES_DM  = 3'd2;
  localparam logic [2:0]  RES_PC  = 3'd3;
  localparam logic [2:0]  RES_MD  = 3'd4;

  // A producer is live only with a nonzero destination and a real result kind.
  function automatic logic writes(input logic [4:0] wa, input logic [2:0] res);
    return (wa != 5'd0) && (res >= RES_ALU) && (res <= RES_MD);
  endfunction

  logic       wvE, wvM, wvW;
  logic [1:0] tnewE, tnewM;

  assign wvE = writes(waE, resE);
  assign wvM = writes(waM, resM);
  assign wvW = writes(waW, resW);

  // Cycles until each producer's result exists (W is always ready).
  always_comb begin
    case (resE)
      RES_DM:  tnewE = 2'd2;
      RES_PC:  tnewE = 2'd0;
      default: tnewE = 2'd1;
    endcase
    tnewM = (resM == RES_DM) ? 2'd1 : 2'd0;
  end

  logic [NUM_SRC-1:0][4:0] raD, raE;
  logic [NUM_SRC-1:0][1:0] tuseD, fwdD, fwdE;
  logic [NUM_SRC-1:0]      dstallD;

  assign raD   = {ra2D, ra1D};
  assign tuseD = {tuse2D, tuse1D};
  assign raE   = {ra2E, ra1E};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    hazard_dsrc u_dsrc (
      .ra(raD[g]), .tuse(tuseD[g]),
      .waE(waE), .wvE(wvE), .tnewE(tnewE),
      .waM(waM), .wvM(wvM), .tnewM(tnewM),
      .waW(waW), .wvW(wvW),
      .dstall(dstallD[g]), .fwd(fwdD[g])
    );

    // E-stage operands: M when its value is ready, else W, else pipeline reg.
    always_comb begin
      fwdE[g] = 2'd0;
      if (wvM && waM == raE[g] && tnewM == 2'd0) fwdE[g] = 2'd2;
      else if (wvW && waW == raE[g])             fwdE[g] = 2'd3;
    end
  end

  assign fwd1D = fwdD[0];
  assign fwd2D = fwdD[1];
  assign fwd1E = fwdE[0];
  assign fwd2E = fwdE[1];
  assign fwd2M = wvW && (waW == ra2M);

  logic md_stall, stall_raw;

  assign md_stall  = md_useD && (md_busy || md_startE);
  assign stall_raw = (|dstallD) || md_stall;
  // A flush kills the D instruction anyway, so holding F/D would be wrong.
  assign stall     = stall_raw && !exc_flush;
  assign DEMWclr   = stall_raw || exc_flush;

  logic [3:0] md_cnt;

  // Busy countdown: a new start reloads; flushes do not cancel an op in flight.
  always_ff @(posedge clk) begin
    if (rst)                 md_cnt <= 4'd0;
    else if (md_startE)      md_cnt <= md_opE ? 4'd10 : 4'd5;
    else if (md_cnt != 4'd0) md_cnt <= md_cnt - 4'd1;
  end

  assign md_busy = (md_cnt != 4'd0);
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations,
// then random tags checked against a table-driven producer model.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ra1D, ra2D, ra1E, ra2E, waE, ra2M, waM, waW;
  logic [1:0] tuse1D, tuse2D;
  logic [2:0] resE, resM, resW;
  logic       md_startE, md_opE, md_useD, exc_flush;
  logic       stall, DEMWclr, fwd2M, md_busy;
  logic [1:0] fwd1D, fwd2D, fwd1E, fwd2E;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .ra1D(ra1D), .ra2D(ra2D), .tuse1D(tuse1D), .tuse2D(tuse2D),
    .ra1E(ra1E), .ra2E(ra2E), .waE(waE), .resE(resE),
    .ra2M(ra2M), .waM(waM), .resM(resM),
    .waW(waW), .resW(resW),
    .md_startE(md_startE), .md_opE(md_opE), .md_useD(md_useD),
    .exc_flush(exc_flush),
    .stall(stall), .DEMWclr(DEMWclr),
    .fwd1D(fwd1D), .fwd2D(fwd2D), .fwd1E(fwd1E), .fwd2E(fwd2E),
    .fwd2M(fwd2M), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Tnew per stage (E, M, W) indexed by result kind NW, ALU, DM, PC, MD.
  localparam int TNEW [3][5] = '{'{0, 1, 2, 0, 1}, '{0, 0, 1, 0, 0}, '{0, 0, 0, 0, 0}};

  // Busy model: the unit is occupied up to (not including) cycle busy_end.
  int cyc = 0;
  int busy_end = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst)            busy_end <= 0;
    else if (md_startE) busy_end <= cyc + 1 + (md_opE ? 10 : 5);
  end

  function automatic logic hit(input logic [4:0] ra, input logic [4:0] wa, input logic [2:0] res);
    return (ra == wa) && (wa != 0) && (res >= 1) && (res <= 4);
  endfunction

  function automatic int tnew(input int stg, input logic [2:0] res);
    if (res > 4) return 0;
    return TNEW[stg][res];
  endfunction

  function automatic logic ref_dstall(input logic [4:0] ra, input logic [1:0] tuse);
    logic [4:0] wa [2];
    logic [2:0] rs [2];
    wa = '{waE, waM};
    rs = '{resE, resM};
    if (tuse == 2'd3) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (hit(ra, wa[s], rs[s])) return tnew(s, rs[s]) > int'(tuse);
    return 1'b0;
  endfunction

  // First stage (nearest first) holding a ready matching value; code = stage+1.
  function automatic logic [1:0] ref_fwd(input logic [4:0] ra, input int first);
    logic [4:0] wa [3];
    logic [2:0] rs [3];
    wa = '{waE, waM, waW};
    rs = '{resE, resM, resW};
    for (int s = first; s < 3; s++)
      if (hit(ra, wa[s], rs[s]) && tnew(s, rs[s]) == 0) return 2'(s + 1);
    return 2'd0;
  endfunction

  task automatic check_model();
    logic data, mds, busy;
    data = ref_dstall(ra1D, tuse1D) | ref_dstall(ra2D, tuse2D);
    busy = (cyc < busy_end);
    mds  = md_useD && (busy || md_startE);
    chk("stall",   stall,   (data || mds) && !exc_flush);
    chk("DEMWclr", DEMWclr, data || mds || exc_flush);
    chk("fwd1D",   fwd1D,   ref_fwd(ra1D, 0));
    chk("fwd2D",   fwd2D,   ref_fwd(ra2D, 0));
    chk("fwd1E",   fwd1E,   ref_fwd(ra1E, 1));
    chk("fwd2E",   fwd2E,   ref_fwd(ra2E, 1));
    chk("fwd2M",   fwd2M,   hit(ra2M, waW, resW));
    chk("md_busy", md_busy, busy);
  endtask

  task automatic idle();
    rst = 0; ra1D = 0; ra2D = 0; tuse1D = 0; tuse2D = 0;
    ra1E = 0; ra2E = 0; waE = 0; resE = 0; ra2M = 0; waM = 0; resM = 0;
    waW = 0; resW = 0; md_startE = 0; md_opE = 0; md_useD = 0; exc_flush = 0;
  endtask

  task automatic settle(); @(negedge clk); endtask
  task automatic tick();   @(posedge clk); #1; endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    // Reset state, all tags zero.
    settle();
    chk("rst_busy",   md_busy, 0);
    chk("rst_stall",  stall,   0);
    chk("rst_clr",    DEMWclr, 0);
    chk("rst_fwd",    {fwd1D, fwd2D, fwd1E, fwd2E, fwd2M}, 0);

    // Load in E feeding a tuse-1 consumer.
    resE = 3'd2; waE = 5'd8; ra1D = 5'd8; tuse1D = 2'd1;
    settle();
    chk("ld_E_stall", stall, 1);
    chk("ld_E_clr",   DEMWclr, 1);
    tick();
    idle(); resM = 3'd2; waM = 5'd8; ra1D = 5'd8; tuse1D = 2'd1;
    settle();
    chk("ld_M_stall", stall, 0);
    chk("ld_M_fwd",   fwd1D, 0);
    tick();
    idle(); resW = 3'd2; waW = 5'd8; ra1D = 5'd8; tuse1D = 2'd1;
    settle();
    chk("ld_W_fwd",   fwd1D, 3);
    tick();
    idle(); resM = 3'd1; waM = 5'd8; ra1D = 5'd8;
    settle();
    chk("alu_M_fwdD", fwd1D, 2);
    tick();
    idle(); resE = 3'd3; waE = 5'd31; ra2D = 5'd31; resM = 3'd1; waM = 5'd31;
    settle();
    chk("pc_E_fwdD",  fwd2D, 1);
    tick();

    // M beats W at E.
    idle(); resM = 3'd1; waM = 5'd5; ra1E = 5'd5; resW = 3'd1; waW = 5'd5;
    settle();
    chk("fwdE_MoverW", fwd1E, 2);
    tick();

    // Register 0 never forwards or stalls.
    idle(); waE = 5'd0; resE = 3'd1; ra1D = 5'd0; tuse1D = 2'd0;
    settle();
    chk("r0_stall", stall, 0);
    chk("r0_fwd",   fwd1D, 0);
    tick();

    // Flush overrides stall but still clears E.
    idle(); resE = 3'd2; waE = 5'd9; ra2D = 5'd9; tuse2D = 2'd0; exc_flush = 1;
    settle();
    chk("flush_stall", stall, 0);
    chk("flush_clr",   DEMWclr, 1);
    tick();

    // Div: busy exactly 10 cycles, md_useD stalls including the start cycle.
    idle(); md_startE = 1; md_opE = 1; md_useD = 1;
    settle();
    chk("div_start_stall", stall, 1);
    tick();
    md_startE = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("div_busy",  md_busy, 1);
      chk("div_stall", stall, 1);
      tick();
    end
    settle();
    chk("div_done_busy",  md_busy, 0);
    chk("div_done_stall", stall, 0);
    tick();

    // Reset mid-div, and reset beating a start.
    idle(); md_startE = 1; md_opE = 1;
    tick();
    md_startE = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    settle();
    chk("rst_mid_div", md_busy, 0);
    tick();
    rst = 1; md_startE = 1; md_opE = 0;
    tick();
    rst = 0; md_startE = 0;
    settle();
    chk("rst_vs_start", md_busy, 0);
    tick();

    // Random tags against the model.
    for (int n = 0; n < 500; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      ra1D      = rreg(); ra2D = rreg();
      tuse1D    = 2'($urandom_range(0, 3)); tuse2D = 2'($urandom_range(0, 3));
      ra1E      = rreg(); ra2E = rreg(); waE = rreg(); resE = 3'($urandom_range(0, 7));
      ra2M      = rreg(); waM = rreg(); resM = 3'($urandom_range(0, 7));
      waW       = rreg(); resW = 3'($urandom_range(0, 7));
      md_startE = ($urandom_range(0, 9) == 0);
      md_opE    = 1'($urandom_range(0, 1));
      md_useD   = ($urandom_range(0, 2) == 0);
      exc_flush = ($urandom_range(0, 7) == 0);
      settle();
      check_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
